csa_tree_adder: RTL

- Pipelined multi-operand adder that sums NUM_OPS operands of WIDTH bits.
- Reduction runs through levels of 3:2 carry-save compressors. Each level is registered.
- A final registered carry-propagate add (CPA) produces the sum.
- Valid/ready handshakes on both sides with bubble-collapsing stalls. Used for dot-product and multiplier partial-product reduction.

---
 rtl/csa_tree_pkg.sv | 44 ++++
 rtl/csa_3_2.sv | 20 ++
 rtl/csa_tree_level.sv | 63 ++++++
 rtl/csa_tree_adder.sv | 91 +++++++++
 4 files changed

// File: rtl/csa_tree_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_tree_pkg : level/operand-count helpers for the CSA tree adder  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package csa_tree_pkg;

    function automatic int csa_next(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int csa_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = csa_next(c);
        end
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = csa_next(c);
            l++;
        end
        return l;
    endfunction

    // Word offset of level lvl's operand vector inside the flattened level bus.
    function automatic int csa_offset(input int n, input int lvl);
        int s;
        s = 0;
        for (int i = 0; i < lvl; i++) begin
            s += csa_count(n, i);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_3_2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_3_2 : 3:2 carry-save compressor, carry pre-shifted             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module csa_3_2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;

endmodule
`default_nettype wire

// File: rtl/csa_tree_level.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_tree_level : one registered 3:2 compression level              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module csa_tree_level
    import csa_tree_pkg::*;
#(
    parameter int  N_IN      = 8,
    parameter int  OUT_WIDTH = 35,
    localparam int c_N_OUT   = csa_count(N_IN, 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic                         i_adv,
    input  logic [N_IN*OUT_WIDTH-1:0]    i_data,
    output logic                         o_valid,
    output logic [c_N_OUT*OUT_WIDTH-1:0] o_data
);

    localparam int c_N_GRP  = N_IN / 3;
    localparam int c_N_PASS = N_IN % 3;

    logic [c_N_OUT*OUT_WIDTH-1:0] w_next;
    logic [c_N_OUT*OUT_WIDTH-1:0] r_data;
    logic                         r_valid;

    for (genvar g = 0; g < c_N_GRP; g++) begin : g_grp
        csa_3_2 #(
            .WIDTH (OUT_WIDTH)
        ) u_csa (
            .i_a     (i_data[(3*g)*OUT_WIDTH   +: OUT_WIDTH]),
            .i_b     (i_data[(3*g+1)*OUT_WIDTH +: OUT_WIDTH]),
            .i_c     (i_data[(3*g+2)*OUT_WIDTH +: OUT_WIDTH]),
            .o_sum   (w_next[(2*g)*OUT_WIDTH   +: OUT_WIDTH]),
            .o_carry (w_next[(2*g+1)*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Leftover operands ride along after the group outputs.
    for (genvar p = 0; p < c_N_PASS; p++) begin : g_pass
        assign w_next[(2*c_N_GRP+p)*OUT_WIDTH +: OUT_WIDTH] =
            i_data[(3*c_N_GRP+p)*OUT_WIDTH +: OUT_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_next;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/csa_tree_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_tree_adder : pipelined multi-operand CSA tree + registered CPA |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module csa_tree_adder
    import csa_tree_pkg::*;
#(
    parameter int  WIDTH     = 32,
    parameter int  NUM_OPS   = 8,
    parameter int  SIGNED    = 0,
    localparam int OUT_WIDTH = WIDTH + $clog2(NUM_OPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_sum
);

    localparam int LEVELS    = csa_levels(NUM_OPS);
    localparam int c_BUS_OPS = csa_offset(NUM_OPS, LEVELS + 1);
    localparam int c_FIN     = csa_offset(NUM_OPS, LEVELS);

    logic [c_BUS_OPS*OUT_WIDTH-1:0] w_bus;
    logic [LEVELS:0]                w_valid;
    logic [LEVELS:0]                w_sv;
    logic [LEVELS:0]                w_adv;
    logic                           r_out_valid;
    logic [OUT_WIDTH-1:0]           r_sum;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
        logic [WIDTH-1:0] w_op;
        assign w_op = in_data[k*WIDTH +: WIDTH];
        if (SIGNED != 0) begin : g_sext
            assign w_bus[k*OUT_WIDTH +: OUT_WIDTH] = {{(OUT_WIDTH-WIDTH){w_op[WIDTH-1]}}, w_op};
        end else begin : g_zext
            assign w_bus[k*OUT_WIDTH +: OUT_WIDTH] = {{(OUT_WIDTH-WIDTH){1'b0}}, w_op};
        end
    end

    // Stage j advances unless it and every later stage are full and the sink stalls;
    // this is the unrolled form of adv_j = !valid_j || adv_(j+1).
    assign w_valid[0] = in_valid;
    assign w_sv       = {r_out_valid, w_valid[LEVELS:1]};

    for (genvar j = 0; j <= LEVELS; j++) begin : g_adv
        assign w_adv[j] = out_ready || !(&w_sv[LEVELS:j]);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int c_N_IN  = csa_count(NUM_OPS, l);
        localparam int c_N_OUT = csa_count(NUM_OPS, l + 1);
        localparam int c_I_OFS = csa_offset(NUM_OPS, l);
        localparam int c_O_OFS = csa_offset(NUM_OPS, l + 1);

        csa_tree_level #(
            .N_IN      (c_N_IN),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[l]),
            .i_adv   (w_adv[l]),
            .i_data  (w_bus[c_I_OFS*OUT_WIDTH +: c_N_IN*OUT_WIDTH]),
            .o_valid (w_valid[l+1]),
            .o_data  (w_bus[c_O_OFS*OUT_WIDTH +: c_N_OUT*OUT_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
        end else if (w_adv[LEVELS]) begin
            r_out_valid <= w_valid[LEVELS];
            if (w_valid[LEVELS]) begin
                r_sum <= w_bus[c_FIN*OUT_WIDTH +: OUT_WIDTH] + w_bus[(c_FIN+1)*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;

endmodule
`default_nettype wire
